tlc_frame_scheduler: RTL and testbench

TLC_FRAME_SCHEDULER -- requirements
Module: tlc_frame_scheduler

---
 rtl/tlc_frame_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_tlc_frame_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_frame_scheduler.sv
// tlc_frame_scheduler
// Sequences a TLC-style LED driver. After reset it loads dot correction, then
// one grayscale frame, and then runs a continuous loop: the grayscale period
// and the next frame shift overlap, and each frame is latched under blank.
// The front buffer flips on frame-shift starts while the writer has a frame
// ready. A stuck engine (no done pulse within TIMEOUT) restarts the sequence.
module tlc_frame_scheduler #(
    parameter int BLANK_PRE  = 2,
    parameter int XLAT_WIDTH = 2,
    parameter int BLANK_POST = 2,
    parameter int TIMEOUT    = 65535
) (
    input  logic        clock,
    input  logic        reset,
    output logic        shift_start,
    input  logic        shift_done,
    output logic        gs_start,
    input  logic        gs_done,
    output logic        led_mode,
    output logic        led_blank,
    output logic        led_xlat,
    output logic        rd_buf,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic [15:0] frame_count,
    output logic        timeout_err
);

    localparam int LATCH_LEN = BLANK_PRE + XLAT_WIDTH + BLANK_POST;
    localparam int LW        = (LATCH_LEN > 1) ? $clog2(LATCH_LEN) : 1;
    localparam int TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_LEN - 1);
    localparam logic [LW-1:0] XLAT_FIRST = LW'(BLANK_PRE);
    localparam logic [LW-1:0] XLAT_LAST  = LW'(BLANK_PRE + XLAT_WIDTH - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        DC_SHIFT,
        DC_LATCH,
        GS_SHIFT,
        GS_LATCH,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          shift_seen_q, shift_seen_d;
    logic          gs_seen_q, gs_seen_d;
    logic          shift_start_q, shift_start_d;
    logic          gs_start_q, gs_start_d;
    logic          mode_q, mode_d;
    logic          blank_q, blank_d;
    logic          xlat_q, xlat_d;
    logic          rd_buf_q, rd_buf_d;
    logic          swap_ack_q, swap_ack_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          timeout_err_q, timeout_err_d;
    logic          sh_any, gs_any;

    // State and registered outputs; reset overrides everything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            lat_cnt_q     <= '0;
            to_cnt_q      <= '0;
            shift_seen_q  <= 1'b0;
            gs_seen_q     <= 1'b0;
            shift_start_q <= 1'b0;
            gs_start_q    <= 1'b0;
            mode_q        <= 1'b1;
            blank_q       <= 1'b1;
            xlat_q        <= 1'b0;
            rd_buf_q      <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_count_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            to_cnt_q      <= to_cnt_d;
            shift_seen_q  <= shift_seen_d;
            gs_seen_q     <= gs_seen_d;
            shift_start_q <= shift_start_d;
            gs_start_q    <= gs_start_d;
            mode_q        <= mode_d;
            blank_q       <= blank_d;
            xlat_q        <= xlat_d;
            rd_buf_q      <= rd_buf_d;
            swap_ack_q    <= swap_ack_d;
            frame_count_q <= frame_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next state: wait states count toward the timeout, latch states count
    // through the blank window, and RUN collects both done pulses.
    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = '0;
        to_cnt_d      = '0;
        shift_seen_d  = 1'b0;
        gs_seen_d     = 1'b0;
        shift_start_d = 1'b0;
        gs_start_d    = 1'b0;
        mode_d        = mode_q;
        frame_count_d = frame_count_q;
        timeout_err_d = timeout_err_q;
        sh_any        = shift_seen_q | shift_done;
        gs_any        = gs_seen_q | gs_done;
        case (state_q)
            IDLE: begin
                state_d       = DC_SHIFT;
                mode_d        = 1'b1;
                shift_start_d = 1'b1;
            end
            DC_SHIFT: begin
                if (shift_done) begin
                    state_d = DC_LATCH;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            DC_LATCH: begin
                if (lat_cnt_q == LATCH_LAST) begin
                    state_d       = GS_SHIFT;
                    mode_d        = 1'b0;
                    shift_start_d = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q + LW'(1);
                end
            end
            GS_SHIFT: begin
                if (shift_done) begin
                    state_d = GS_LATCH;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            GS_LATCH: begin
                if (lat_cnt_q == LATCH_LAST) begin
                    state_d       = RUN;
                    frame_count_d = frame_count_q + 16'd1;
                    gs_start_d    = 1'b1;
                    shift_start_d = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q + LW'(1);
                end
            end
            RUN: begin
                if (sh_any && gs_any) begin
                    state_d = GS_LATCH;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    to_cnt_d     = to_cnt_q + TW'(1);
                    shift_seen_d = sh_any;
                    gs_seen_d    = gs_any;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so every output comes off a flop;
    // the buffer flip is tied to a grayscale shift start.
    always_comb begin
        blank_d    = (state_d != RUN);
        xlat_d     = ((state_d == DC_LATCH) || (state_d == GS_LATCH)) &&
                     (lat_cnt_d >= XLAT_FIRST) && (lat_cnt_d <= XLAT_LAST);
        rd_buf_d   = rd_buf_q;
        swap_ack_d = 1'b0;
        if (shift_start_d && !mode_d && swap_req) begin
            rd_buf_d   = ~rd_buf_q;
            swap_ack_d = 1'b1;
        end
    end

    assign shift_start = shift_start_q;
    assign gs_start    = gs_start_q;
    assign led_mode    = mode_q;
    assign led_blank   = blank_q;
    assign led_xlat    = xlat_q;
    assign rd_buf      = rd_buf_q;
    assign swap_ack    = swap_ack_q;
    assign frame_count = frame_count_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_tlc_frame_scheduler.sv
// Directed bench for tlc_frame_scheduler: startup load, done ordering,
// buffer swap, frame counter wrap, timeout restart and mid-operation reset.
module tb_tlc_frame_scheduler;

    logic        clock;
    logic        reset;
    logic        shift_start;
    logic        shift_done;
    logic        gs_start;
    logic        gs_done;
    logic        led_mode;
    logic        led_blank;
    logic        led_xlat;
    logic        rd_buf;
    logic        swap_req;
    logic        swap_ack;
    logic [15:0] frame_count;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;
    int ack_bad = 0;
    int xlat_viol = 0;

    tlc_frame_scheduler #(.TIMEOUT(100)) dut (
        .clock       (clock),
        .reset       (reset),
        .shift_start (shift_start),
        .shift_done  (shift_done),
        .gs_start    (gs_start),
        .gs_done     (gs_done),
        .led_mode    (led_mode),
        .led_blank   (led_blank),
        .led_xlat    (led_xlat),
        .rd_buf      (rd_buf),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_count (frame_count),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Background monitors sampled away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (swap_ack === 1'b1) ack_cnt++;
            if (swap_ack === 1'b1 && shift_start !== 1'b1) ack_bad++;
            if (led_xlat === 1'b1 && led_blank !== 1'b1) xlat_viol++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Records six latch-window cycles; optionally injects done pulses mid-window.
    task automatic sample_latch(input bit inject, output logic [5:0] xl, output logic [5:0] bl);
        for (int i = 0; i < 6; i++) begin
            xl[i] = led_xlat;
            bl[i] = led_blank;
            shift_done = inject && (i == 2);
            gs_done    = inject && (i == 2);
            tick();
        end
        shift_done = 1'b0;
        gs_done    = 1'b0;
    endtask

    // Drives done pulses at the given RUN-relative cycles; flags any blank before the last.
    task automatic finish_frame(input int gs_at, input int sh_at, output bit early);
        int last;
        last  = (gs_at > sh_at) ? gs_at : sh_at;
        early = 1'b0;
        for (int c = 0; c <= last; c++) begin
            if (led_blank !== 1'b0) early = 1'b1;
            gs_done    = (c == gs_at);
            shift_done = (c == sh_at);
            tick();
        end
        gs_done    = 1'b0;
        shift_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; shift_done = 1'b0; gs_done = 1'b0; swap_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total++; if (shift_start !== 1'b0) begin bad++; $display("FAIL reset_shift_start got=%b want=0", shift_start); end
        total++; if (gs_start !== 1'b0) begin bad++; $display("FAIL reset_gs_start got=%b want=0", gs_start); end
        total++; if (swap_ack !== 1'b0) begin bad++; $display("FAIL reset_swap_ack got=%b want=0", swap_ack); end
        total++; if (led_xlat !== 1'b0) begin bad++; $display("FAIL reset_xlat got=%b want=0", led_xlat); end
        total++; if (led_blank !== 1'b1) begin bad++; $display("FAIL reset_blank got=%b want=1", led_blank); end
        total++; if (led_mode !== 1'b1) begin bad++; $display("FAIL reset_mode got=%b want=1", led_mode); end
        total++; if (rd_buf !== 1'b0) begin bad++; $display("FAIL reset_rd_buf got=%b want=0", rd_buf); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL reset_frame_count got=%0d want=0", frame_count); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b want=0", timeout_err); end
    endtask

    task automatic test_startup();
        logic [5:0] xl, bl;
        reset = 1'b0;
        tick();
        total++; if (shift_start !== 1'b1) begin bad++; $display("FAIL startup_dc_shift_start got=%b want=1", shift_start); end
        total++; if (led_mode !== 1'b1) begin bad++; $display("FAIL startup_dc_mode got=%b want=1", led_mode); end
        for (int i = 0; i < 9; i++) tick();
        shift_done = 1'b1; tick(); shift_done = 1'b0;
        sample_latch(1'b0, xl, bl);
        total++; if (xl !== 6'b001100) begin bad++; $display("FAIL startup_dc_xlat got=%b want=001100", xl); end
        total++; if (bl !== 6'b111111) begin bad++; $display("FAIL startup_dc_blank got=%b want=111111", bl); end
        total++; if (shift_start !== 1'b1) begin bad++; $display("FAIL startup_gs_shift_start got=%b want=1", shift_start); end
        total++; if (led_mode !== 1'b0) begin bad++; $display("FAIL startup_gs_mode got=%b want=0", led_mode); end
        total++; if (gs_start !== 1'b0) begin bad++; $display("FAIL startup_early_gs_start got=%b want=0", gs_start); end
        for (int i = 0; i < 9; i++) tick();
        shift_done = 1'b1; tick(); shift_done = 1'b0;
        sample_latch(1'b0, xl, bl);
        total++; if (xl !== 6'b001100) begin bad++; $display("FAIL startup_gs_xlat got=%b want=001100", xl); end
        total++; if (gs_start !== 1'b1) begin bad++; $display("FAIL startup_run_gs_start got=%b want=1", gs_start); end
        total++; if (shift_start !== 1'b1) begin bad++; $display("FAIL startup_run_shift_start got=%b want=1", shift_start); end
        total++; if (led_blank !== 1'b0) begin bad++; $display("FAIL startup_run_blank got=%b want=0", led_blank); end
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL startup_frame_count got=%0d want=1", frame_count); end
    endtask

    task automatic test_done_order();
        int ga[3] = '{0, 20, 5};
        int sa[3] = '{20, 0, 5};
        logic [5:0] xl, bl;
        bit early;
        for (int k = 0; k < 3; k++) begin
            finish_frame(ga[k], sa[k], early);
            total++; if (early !== 1'b0) begin bad++; $display("FAIL done_order_early case=%0d got=%b want=0", k, early); end
            total++; if (led_blank !== 1'b1) begin bad++; $display("FAIL done_order_latch case=%0d got=%b want=1", k, led_blank); end
            sample_latch(1'b0, xl, bl);
            total++; if (xl !== 6'b001100) begin bad++; $display("FAIL done_order_xlat case=%0d got=%b want=001100", k, xl); end
            total++; if (frame_count !== 16'(2 + k)) begin bad++; $display("FAIL done_order_count case=%0d got=%0d want=%0d", k, frame_count, 2 + k); end
            total++; if (gs_start !== 1'b1) begin bad++; $display("FAIL done_order_gs_start case=%0d got=%b want=1", k, gs_start); end
        end
    endtask

    task automatic test_ignore_latch_done();
        logic [5:0] xl, bl;
        bit early;
        finish_frame(0, 0, early);
        sample_latch(1'b1, xl, bl);
        total++; if (frame_count !== 16'd5) begin bad++; $display("FAIL ignore_count_a got=%0d want=5", frame_count); end
        finish_frame(10, 10, early);
        total++; if (early !== 1'b0) begin bad++; $display("FAIL ignore_latch_done got=%b want=0", early); end
        sample_latch(1'b0, xl, bl);
        total++; if (frame_count !== 16'd6) begin bad++; $display("FAIL ignore_count_b got=%0d want=6", frame_count); end
    endtask

    task automatic test_swap();
        logic [5:0] xl, bl;
        bit early;
        int ack0;
        ack0 = ack_cnt;
        total++; if (rd_buf !== 1'b0) begin bad++; $display("FAIL swap_initial got=%b want=0", rd_buf); end
        swap_req = 1'b1;
        for (int f = 0; f < 3; f++) begin
            finish_frame(3, 3, early);
            sample_latch(1'b0, xl, bl);
            total++; if (swap_ack !== 1'b1 || shift_start !== 1'b1) begin bad++; $display("FAIL swap_ack frame=%0d got=%b/%b want=1/1", f, swap_ack, shift_start); end
            total++; if (rd_buf !== ((f % 2) == 0)) begin bad++; $display("FAIL swap_rd_buf frame=%0d got=%b want=%b", f, rd_buf, (f % 2) == 0); end
        end
        tick();
        swap_req = 1'b0;
        total++; if (ack_cnt - ack0 !== 3) begin bad++; $display("FAIL swap_ack_count got=%0d want=3", ack_cnt - ack0); end
        total++; if (ack_bad !== 0) begin bad++; $display("FAIL swap_ack_alone got=%0d want=0", ack_bad); end
    endtask

    task automatic test_wrap();
        logic [5:0] xl, bl;
        bit early;
        force dut.frame_count_q = 16'hFFFF;
        tick();
        release dut.frame_count_q;
        #1;
        total++; if (frame_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%0d want=65535", frame_count); end
        finish_frame(1, 1, early);
        sample_latch(1'b0, xl, bl);
        total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL wrap_zero got=%0d want=0", frame_count); end
        finish_frame(0, 0, early);
        sample_latch(1'b0, xl, bl);
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL wrap_after got=%0d want=1", frame_count); end
    endtask

    task automatic test_timeout();
        bit err_early = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (timeout_err !== 1'b0) err_early = 1'b1;
            shift_done = (n == 10);
            tick();
        end
        shift_done = 1'b0;
        total++; if (err_early !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b want=0", err_early); end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b want=1", timeout_err); end
        total++; if (led_blank !== 1'b1) begin bad++; $display("FAIL timeout_blank got=%b want=1", led_blank); end
        tick();
        total++; if (shift_start !== 1'b1 || led_mode !== 1'b1) begin bad++; $display("FAIL timeout_restart got=%b/%b want=1/1", shift_start, led_mode); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) tick();
        shift_done = 1'b1; tick(); shift_done = 1'b0;
        for (int i = 0; i < 8 && led_xlat !== 1'b1; i++) tick();
        total++; if (led_xlat !== 1'b1) begin bad++; $display("FAIL midrst_xlat_seen got=%b want=1", led_xlat); end
        reset = 1'b1;
        tick();
        total++; if (led_xlat !== 1'b0) begin bad++; $display("FAIL midrst_xlat got=%b want=0", led_xlat); end
        total++; if (led_blank !== 1'b1) begin bad++; $display("FAIL midrst_blank got=%b want=1", led_blank); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", frame_count); end
        total++; if (rd_buf !== 1'b0) begin bad++; $display("FAIL midrst_rd_buf got=%b want=0", rd_buf); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b want=0", timeout_err); end
        reset = 1'b0;
        tick();
        total++; if (shift_start !== 1'b1 || led_mode !== 1'b1) begin bad++; $display("FAIL midrst_restart got=%b/%b want=1/1", shift_start, led_mode); end
        total++; if (xlat_viol !== 0) begin bad++; $display("FAIL xlat_without_blank got=%0d want=0", xlat_viol); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_done_order();
        test_ignore_latch_done();
        test_swap();
        test_wrap();
        test_timeout();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
